// File: rtl/fb_loader_if.sv
// fb_loader_if: byte stream handshake into the framebuffer loader.
// master drives in_data/in_valid, slave answers with in_ready.
interface fb_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/fb_loader.sv
// fb_loader: unpacks 1-bpp bytes into a 64x64 framebuffer write port.
// Define FB_CLEAR_EN to build the CLEAR state (zero-fill on clear).
module fb_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  fb_loader_if.slave  src,
  output logic        wren,
  output logic        data,
  output logic [11:0] wraddress,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CLEAR,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [11:0] addr;
  logic [11:0] addr_nx;
  logic [7:0]  shift;
  logic [7:0]  shift_nx;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nx;
  logic        accept;
  logic        clr_req;

  logic        ready_nx;
  logic        wren_nx;
  logic        data_nx;
  logic [11:0] wraddress_nx;
  logic        busy_nx;
  logic        done_nx;

`ifdef FB_CLEAR_EN
  assign clr_req = clear & ~start;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign clr_req      = 1'b0;
`endif

  assign accept = (state == LOAD)
                & src.in_valid
                & src.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      addr          <= '0;
      shift         <= '0;
      cnt           <= '0;
      src.in_ready  <= 1'b0;
      wren          <= 1'b0;
      data          <= 1'b0;
      wraddress     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      addr          <= addr_nx;
      shift         <= shift_nx;
      cnt           <= cnt_nx;
      src.in_ready  <= ready_nx;
      wren          <= wren_nx;
      data          <= data_nx;
      wraddress     <= wraddress_nx;
      busy          <= busy_nx;
      done          <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    shift_nx = shift;
    cnt_nx   = cnt;
    unique case (1'b1)
      state == IDLE: begin
        if (start) begin
          state_nx = LOAD;
          addr_nx  = '0;
        end else if (clr_req) begin
          state_nx = CLEAR;
          addr_nx  = '0;
        end
      end
      state == LOAD: begin
        if (accept) begin
          state_nx = SHIFT;
          shift_nx = src.in_data;
          cnt_nx   = '0;
        end
      end
      state == SHIFT: begin
        shift_nx = {shift[6:0], 1'b0};
        addr_nx  = addr + 12'd1;
        cnt_nx   = cnt + 3'd1;
        // the byte ending on the last pixel closes the frame
        if (cnt == 3'd7) begin
          if (addr == 12'hFFF) state_nx = DONE;
          else                 state_nx = LOAD;
        end
      end
`ifdef FB_CLEAR_EN
      state == CLEAR: begin
        addr_nx = addr + 12'd1;
        if (addr == 12'hFFF) state_nx = DONE;
      end
`endif
      state == DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // outputs are one-cycle registered images of the current state
  always_comb begin
    ready_nx     = (state == LOAD) & ~accept;
    wren_nx      = (state == SHIFT) | (state == CLEAR);
    data_nx      = (state == SHIFT) & shift[7];
    wraddress_nx = wren_nx ? addr : wraddress;
    busy_nx      = (state != IDLE);
    done_nx      = (state == DONE);
  end

endmodule

// File: tb/tb_fb_loader.sv
// tb_fb_loader: table vectors, hand sequences and random frames
// checked against a pixel-level framebuffer model.
module tb_fb_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        wren;
  logic        data;
  logic [11:0] wraddress;
  logic        busy;
  logic        done;

  fb_loader_if bus ();

  fb_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .src       (bus),
    .wren      (wren),
    .data      (data),
    .wraddress (wraddress),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic        d;
  } wr_t;

  typedef struct {
    logic [7:0]  din;
    int          gap;
    logic [7:0]  bits;
    logic [11:0] addr;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  wr_t         wr_q[$];
  logic        ram[4096];
  int          done_cnt = 0;
  int          viol_data = 0;
  int          viol_hold = 0;
  logic [11:0] prev_addr = '0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_addr = '0;
    end else begin
      if (wren === 1'b1) begin
        wr_q.push_back('{a: wraddress, d: data});
        ram[wraddress] = data;
      end else begin
        if (data !== 1'b0) viol_data++;
        if (wraddress !== prev_addr) viol_hold++;
      end
      if (done === 1'b1) done_cnt++;
      prev_addr = wraddress;
    end
  end

  task automatic do_reset();
    #2;
    reset        = 1'b0;
    start        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap,
                           input bit hold);
    int k;
    if (!hold) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("ready_wait", bus.in_ready, 1);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input bit rnd);
    logic [7:0] bytes[512];
    int idx0, dc0, k, bad, bad_ram;
    logic exp;
    idx0 = wr_q.size();
    dc0  = done_cnt;
    pulse_start();
    for (int i = 0; i < 512; i++) begin
      bytes[i] = rnd ? 8'($urandom) : 8'hA5;
      send_byte(bytes[i],
                rnd ? int'($urandom_range(0, 3)) : 0,
                !rnd);
    end
    bus.in_valid = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("frame_done", done, 1);
    check("frame_done_wren", wren, 0);
    @(negedge clk);
    check("frame_done_pulse", done, 0);
    check("frame_busy_after", busy, 0);
    check("frame_nwr", wr_q.size() - idx0, 4096);
    bad = 0;
    bad_ram = 0;
    for (int a = 0; a < 4096; a++) begin
      exp = bytes[a / 8][7 - (a % 8)];
      if (idx0 + a < wr_q.size()) begin
        if (wr_q[idx0 + a].a !== 12'(a) ||
            wr_q[idx0 + a].d !== exp) bad++;
      end
      if (ram[a] !== exp) bad_ram++;
    end
    check("frame_writes", bad, 0);
    check("frame_ram", bad_ram, 0);
    check("frame_done_cnt", done_cnt - dc0, 1);
  endtask

  initial begin : wd
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[5];
    int   idx0, k, bad, rdy_seen, dc0;
    logic [7:0] b80;

    tbl[0] = '{din: 8'h01, gap: 20, bits: 8'b0000_0001, addr: 12'd8};
    tbl[1] = '{din: 8'hFF, gap: 0,  bits: 8'b1111_1111, addr: 12'd16};
    tbl[2] = '{din: 8'h00, gap: 3,  bits: 8'b0000_0000, addr: 12'd24};
    tbl[3] = '{din: 8'h5A, gap: 1,  bits: 8'b0101_1010, addr: 12'd32};
    tbl[4] = '{din: 8'hC3, gap: 7,  bits: 8'b1100_0011, addr: 12'd40};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    check("rst_wren", wren, 0);
    check("rst_data", data, 0);
    check("rst_wraddress", wraddress, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    do_reset();

    // single 0x80 byte, cycle-exact
    pulse_start();
    b80 = 8'h80;
    send_byte(b80, 0, 0);
    check("lat_n0_wren", wren, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("lat_wren", wren, 1);
      check("lat_data", data, b80[7 - i]);
      check("lat_addr", wraddress, i);
      check("lat_ready_low", bus.in_ready, 0);
    end
    @(negedge clk);
    check("lat_ready_n9", bus.in_ready, 1);
    check("lat_wren_n9", wren, 0);

    foreach (tbl[j]) begin
      idx0 = wr_q.size();
      send_byte(tbl[j].din, tbl[j].gap, 0);
      repeat (10) @(negedge clk);
      check("tbl_nwr", wr_q.size() - idx0, 8);
      for (int i = 0; i < 8; i++) begin
        if (idx0 + i < wr_q.size()) begin
          check("tbl_addr", wr_q[idx0 + i].a, tbl[j].addr + 12'(i));
          check("tbl_bit", wr_q[idx0 + i].d, tbl[j].bits[7 - i]);
        end
      end
    end

    // asynchronous abort in the middle of a byte
    do_reset();
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), 0, 0);
    send_byte(8'hFF, 0, 0);
    k = 0;
    while (!(wren === 1'b1 && wraddress === 12'd100) && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("abort_at100", wraddress, 100);
    #2;
    reset = 1'b0;
    #1;
    check("abort_wren", wren, 0);
    check("abort_data", data, 0);
    check("abort_wraddress", wraddress, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    idx0 = wr_q.size();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_nowr", wr_q.size() - idx0, 0);
    check("abort_idle_busy", busy, 0);
    pulse_start();
    send_byte(8'h80, 0, 0);
    repeat (10) @(negedge clk);
    check("abort_restart_nwr", wr_q.size() - idx0, 8);
    if (wr_q.size() > idx0) begin
      check("abort_restart_addr", wr_q[idx0].a, 0);
      check("abort_restart_bit", wr_q[idx0].d, 1);
    end

    do_reset();
    run_frame(1'b0);
    run_frame(1'b1);

`ifdef FB_CLEAR_EN
    idx0 = wr_q.size();
    dc0  = done_cnt;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    rdy_seen = 0;
    k = 0;
    while (done !== 1'b1 && k < 4200) begin
      @(negedge clk);
      k++;
      start = (k % 500 == 3);
      if (bus.in_ready === 1'b1) rdy_seen++;
    end
    start = 1'b0;
    check("clr_done", done, 1);
    check("clr_done_wren", wren, 0);
    check("clr_ready_seen", rdy_seen, 0);
    check("clr_nwr", wr_q.size() - idx0, 4096);
    bad = 0;
    for (int a = 0; a < 4096; a++) begin
      if (idx0 + a < wr_q.size()) begin
        if (wr_q[idx0 + a].a !== 12'(a) ||
            wr_q[idx0 + a].d !== 1'b0) bad++;
      end
      if (ram[a] !== 1'b0) bad++;
    end
    check("clr_writes", bad, 0);
    @(negedge clk);
    check("clr_done_pulse", done, 0);
    check("clr_busy_after", busy, 0);
    check("clr_done_cnt", done_cnt - dc0, 1);
    start = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    check("both_ready", bus.in_ready, 1);
    check("both_wren", wren, 0);
    do_reset();
`else
    clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("clr_ign_wren", wren, 0);
      check("clr_ign_busy", busy, 0);
    end
    clear = 1'b0;
`endif

    check("data_when_idle", viol_data, 0);
    check("addr_hold", viol_hold, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
